dac_spi_rx: RTL and testbench
=============================

Name: dac_spi_rx

Overview:
- SPI slave that receives the 32-bit DAC command frames our SPI master sends. The frame layout is 8 don't-care bits, cmd[3:0], addr[3:0], data[11:0], then 4 don't-care bits, MSB first.
- Decodes each frame and maintains a 4-channel DAC register model: input registers, output registers and power-down flags.
- Used as the DAC-side model in system simulation and as an on-chip frame checker. Runs entirely in the system clock domain with oversampled SPI inputs.

Parameters:
- FRAME_BITS, 32, number of sck rising edges in a valid frame.
- SYNC_STAGES, 2, synchroniser depth for spi_sck, spi_mosi and dac_cs; legal range 2..3.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- spi_sck  in  1  SPI clock from the master; idles low.
- spi_mosi  in  1  serial data, sampled on the sck rising edge.
- dac_cs  in  1  chip select, active-low.
- dac_clr  in  1  active-low clear; synchronous to clk after synchronisation.
- frame_valid  out  1  one-clk pulse when a good frame is accepted.
- frame_err  out  1  one-clk pulse when a frame has a bad bit count.
- rx_cmd  out  4  cmd field of the last good frame.
- rx_addr  out  4  addr field of the last good frame.
- rx_data  out  12  data field of the last good frame.
- dac_out  out  48  output registers; channel A in [11:0] up to channel D in [47:36].
- pwr_dn  out  4  per-channel power-down flags; bit0 is channel A.

Behaviour:
- Reset: every register and output is 0; FSM is in IDLE. Reset is async-asserted and takes effect immediately, including mid-frame; the partial frame is discarded.
- Synchronisers: sck, mosi and cs each pass through SYNC_STAGES flops.
  - An sck rise is detected as synced sck 0->1 on consecutive clks.
  - cs fall and rise are detected the same way.
  - Required input timing: sck high and low phases each >= 2 clk periods.
- FSM states:
  - IDLE: on cs fall, clear the 6-bit bit counter and the 32-bit shift register, then go to SHIFT.
  - SHIFT: on each sck rise, shift the register left with mosi entering at the LSB, and increment the counter. The counter saturates at 63. On cs rise, go to CHECK.
  - CHECK: one cycle, then back to IDLE.
    - If count == FRAME_BITS: frame_valid=1, latch rx_cmd=sr[23:20], rx_addr=sr[19:16], rx_data=sr[15:4], and apply the command below.
    - Otherwise: frame_err=1 and no state changes.
- Latency: frame_valid asserts exactly SYNC_STAGES+2 clk after dac_cs rises at the pin. dac_out and pwr_dn update on the same clk edge that raises frame_valid.
- Commands; channel set is addr 0..3 for A..D, addr 4'hF for all four, any other addr selects none (frame still valid):
  - 0000: input_reg[ch] = data.
  - 0001: dac_out[ch] = input_reg[ch], pwr_dn[ch] = 0.
  - 0010: input_reg[ch] = data, then every channel's dac_out = input_reg, pwr_dn cleared for all.
  - 0011: input_reg[ch] = dac_out[ch] = data, pwr_dn[ch] = 0.
  - 0100: pwr_dn[ch] = 1; registers unchanged.
  - Anything else (1111 no-op included): frame_valid still pulses; no register change.
- Mid-frame sck when cs is high: ignored.
- cs fall while in CHECK: handled on the next clk in IDLE. Because of the synchroniser delay, no edge is lost.
- dac_clr low (synchronised):
  - All input_reg, dac_out and pwr_dn are held at 0 while low.
  - A frame completing while dac_clr is low still pulses frame_valid and latches rx_*, but does not apply the command.
  - The shifter keeps running.

Optional Feature:
- Macro DAC_SPI_RX_READBACK_EN.
- Defined: adds output spi_miso (out, 1).
  - It echoes the previous good frame MSB first, for daisy-chain readback.
  - A 32-bit echo register loads the shift register on frame_valid.
  - spi_miso presents bit 31 from cs fall. It shifts left by one on each synced sck fall while in SHIFT.
  - It is 0 when cs is high and after reset.
- Undefined: no spi_miso port and no echo register; all other behaviour is identical.

Test Plan:
- Reset, then frame 0x0033ABC0 (cmd 0011, addr 3, data 0xABC) -> frame_valid pulse 4 clk after cs rises; dac_out[47:36]=0xABC; other channels 0; pwr_dn=0.
- Frame cmd 0000 addr F data 0x123, then cmd 0001 addr 1 -> after the first frame dac_out=0; after the second only dac_out[23:12]=0x123.
- Frame cmd 0100 addr 2, then cmd 0011 addr 2 data 0x7FF -> pwr_dn=4'b0100, then 4'b0000 with dac_out[35:24]=0x7FF.
- Frame of 31 sck edges, then a frame of 33 edges -> two frame_err pulses, no frame_valid, dac_out and pwr_dn unchanged.
- Assert rst at sck edge 16 of a frame, release, then send a full 0x0030FFF0 -> first frame discarded; dac_out[11:0]=0xFFF.
- With DAC_SPI_RX_READBACK_EN: send 0x0033ABC0 then 0x00F00000 -> spi_miso bit stream during the second frame equals 0x0033ABC0.

Source files
------------

// File: rtl/dac_spi_rx.sv
// rtl/dac_spi_rx.sv - SPI slave for 32-bit DAC command frames with a 4-channel DAC register model.
// Optional readback echo on spi_miso is enabled by defining DAC_SPI_RX_READBACK_EN.
module dac_spi_rx #(
   parameter int FRAME_BITS  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_sck,
   input  logic        spi_mosi,
   input  logic        dac_cs,
   input  logic        dac_clr,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [3:0]  rx_cmd,
   output logic [3:0]  rx_addr,
   output logic [11:0] rx_data,
   output logic [47:0] dac_out,
   output logic [3:0]  pwr_dn
`ifdef DAC_SPI_RX_READBACK_EN
   ,
   output logic        spi_miso
`endif
);

   localparam logic [5:0] LP_FRAME_BITS = 6'(FRAME_BITS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_clr_sync;
   logic                   r_sck_d;
   logic                   r_cs_d;
   logic                   r_fall_pend;

   logic        w_sck;
   logic        w_mosi;
   logic        w_cs;
   logic        w_clr_n;
   logic        w_sck_rise;
   logic        w_cs_fall;
   logic        w_cs_rise;
   logic        w_start;
   logic        w_good;

   logic [5:0]  r_cnt;
   logic [31:0] r_sr;

   logic [3:0]  w_cmd;
   logic [3:0]  w_addr;
   logic [11:0] w_data;
   logic [3:0]  w_mask;

   logic [11:0] r_in  [4];
   logic [11:0] r_out [4];
   logic [3:0]  r_pd;
   logic [11:0] w_in_nxt  [4];
   logic [11:0] w_out_nxt [4];
   logic [3:0]  w_pd_nxt;

   logic        r_frame_valid;
   logic        r_frame_err;
   logic [3:0]  r_rx_cmd;
   logic [3:0]  r_rx_addr;
   logic [11:0] r_rx_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= '0;
         r_clr_sync  <= '0;
         r_sck_d     <= 1'b0;
         r_cs_d      <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], dac_cs};
         r_clr_sync  <= {r_clr_sync[SYNC_STAGES-2:0], dac_clr};
         r_sck_d     <= w_sck;
         r_cs_d      <= w_cs;
      end
   end

   assign w_sck      = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs       = r_cs_sync[SYNC_STAGES-1];
   assign w_clr_n    = r_clr_sync[SYNC_STAGES-1];
   assign w_sck_rise = w_sck & ~r_sck_d;
   assign w_cs_fall  = ~w_cs & r_cs_d;
   assign w_cs_rise  = w_cs & ~r_cs_d;
   // A cs fall seen during CHECK is remembered so IDLE can still start the frame.
   assign w_start    = w_cs_fall | r_fall_pend;
   assign w_good     = (r_cnt == LP_FRAME_BITS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_start) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_cs_rise) w_state_nxt = ST_CHECK;
         ST_CHECK: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_sr        <= '0;
         r_fall_pend <= 1'b0;
      end else begin
         if (r_state == ST_CHECK && w_cs_fall) begin
            r_fall_pend <= 1'b1;
         end else if (r_state == ST_IDLE) begin
            r_fall_pend <= 1'b0;
         end
         if (r_state == ST_IDLE && w_start) begin
            r_cnt <= '0;
            r_sr  <= '0;
         end else if (r_state == ST_SHIFT && w_sck_rise) begin
            r_sr  <= {r_sr[30:0], w_mosi};
            r_cnt <= (r_cnt == 6'd63) ? r_cnt : r_cnt + 6'd1;
         end
      end
   end

   assign w_cmd  = r_sr[23:20];
   assign w_addr = r_sr[19:16];
   assign w_data = r_sr[15:4];

   always_comb begin
      w_mask = 4'b0000;
      if (w_addr == 4'hF) begin
         w_mask = 4'b1111;
      end else if (w_addr < 4'd4) begin
         w_mask = 4'b0001 << w_addr[1:0];
      end
   end

   // Next register-file contents if the current frame's command were applied.
   always_comb begin
      w_in_nxt  = r_in;
      w_out_nxt = r_out;
      w_pd_nxt  = r_pd;
      for (int c = 0; c < 4; c++) begin
         if (w_mask[c]) begin
            case (w_cmd)
               4'b0000: w_in_nxt[c] = w_data;
               4'b0001: begin
                  w_out_nxt[c] = r_in[c];
                  w_pd_nxt[c]  = 1'b0;
               end
               4'b0010: w_in_nxt[c] = w_data;
               4'b0011: begin
                  w_in_nxt[c]  = w_data;
                  w_out_nxt[c] = w_data;
                  w_pd_nxt[c]  = 1'b0;
               end
               4'b0100: w_pd_nxt[c] = 1'b1;
               default: ;
            endcase
         end
      end
      if (w_cmd == 4'b0010) begin
         for (int c = 0; c < 4; c++) begin
            w_out_nxt[c] = w_in_nxt[c];
         end
         w_pd_nxt = 4'b0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_rx_cmd      <= '0;
         r_rx_addr     <= '0;
         r_rx_data     <= '0;
         r_pd          <= '0;
         for (int c = 0; c < 4; c++) begin
            r_in[c]  <= '0;
            r_out[c] <= '0;
         end
      end else begin
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         if (r_state == ST_CHECK) begin
            if (w_good) begin
               r_frame_valid <= 1'b1;
               r_rx_cmd      <= w_cmd;
               r_rx_addr     <= w_addr;
               r_rx_data     <= w_data;
               if (w_clr_n) begin
                  r_in  <= w_in_nxt;
                  r_out <= w_out_nxt;
                  r_pd  <= w_pd_nxt;
               end
            end else begin
               r_frame_err <= 1'b1;
            end
         end
         if (!w_clr_n) begin
            r_pd <= '0;
            for (int c = 0; c < 4; c++) begin
               r_in[c]  <= '0;
               r_out[c] <= '0;
            end
         end
      end
   end

   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign rx_cmd      = r_rx_cmd;
   assign rx_addr     = r_rx_addr;
   assign rx_data     = r_rx_data;
   assign dac_out     = {r_out[3], r_out[2], r_out[1], r_out[0]};
   assign pwr_dn      = r_pd;

`ifdef DAC_SPI_RX_READBACK_EN
   logic [31:0] r_echo;
   logic [31:0] r_miso_sr;
   logic        w_sck_fall;

   assign w_sck_fall = ~w_sck & r_sck_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_echo    <= '0;
         r_miso_sr <= '0;
      end else begin
         if (r_state == ST_CHECK && w_good) begin
            r_echo <= r_sr;
         end
         if (r_state == ST_IDLE && w_start) begin
            r_miso_sr <= r_echo;
         end else if (r_state == ST_SHIFT && w_sck_fall) begin
            r_miso_sr <= {r_miso_sr[30:0], 1'b0};
         end
      end
   end

   assign spi_miso = (r_state == ST_SHIFT) ? r_miso_sr[31] : 1'b0;
`else
   logic w_unused_sr_msb;
   assign w_unused_sr_msb = r_sr[31];
`endif

endmodule

// File: tb/tb_dac_spi_rx.sv
// tb/tb_dac_spi_rx.sv - directed and randomized self-checking bench for dac_spi_rx.
module tb_dac_spi_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_sck;
   logic        spi_mosi;
   logic        dac_cs;
   logic        dac_clr;
   logic        frame_valid;
   logic        frame_err;
   logic [3:0]  rx_cmd;
   logic [3:0]  rx_addr;
   logic [11:0] rx_data;
   logic [47:0] dac_out;
   logic [3:0]  pwr_dn;
`ifdef DAC_SPI_RX_READBACK_EN
   logic        spi_miso;
   logic [31:0] miso_word;
`endif

   int nvec = 0;
   int nerr = 0;

   logic [11:0] m_in  [4];
   logic [11:0] m_out [4];
   logic [3:0]  m_pd;
   logic [3:0]  m_cmd;
   logic [3:0]  m_addr;
   logic [11:0] m_data;

   always #5 clk = ~clk;

   dac_spi_rx #(.FRAME_BITS(32), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .dac_cs      (dac_cs),
      .dac_clr     (dac_clr),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .rx_cmd      (rx_cmd),
      .rx_addr     (rx_addr),
      .rx_data     (rx_data),
      .dac_out     (dac_out),
      .pwr_dn      (pwr_dn)
`ifdef DAC_SPI_RX_READBACK_EN
      ,
      .spi_miso    (spi_miso)
`endif
   );

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         m_in[c]  = '0;
         m_out[c] = '0;
      end
      m_pd   = '0;
      m_cmd  = '0;
      m_addr = '0;
      m_data = '0;
   endtask

   // Command semantics written directly from the channel/command table.
   task automatic model_frame(input logic [31:0] f, input bit clr_low);
      bit sel;
      m_cmd  = f[23:20];
      m_addr = f[19:16];
      m_data = f[15:4];
      if (clr_low) return;
      for (int c = 0; c < 4; c++) begin
         sel = (m_addr == 4'hF) || (int'(m_addr) == c);
         if (sel) begin
            if (m_cmd == 0 || m_cmd == 2) m_in[c] = m_data;
            if (m_cmd == 1) begin m_out[c] = m_in[c]; m_pd[c] = 1'b0; end
            if (m_cmd == 3) begin m_in[c] = m_data; m_out[c] = m_data; m_pd[c] = 1'b0; end
            if (m_cmd == 4) m_pd[c] = 1'b1;
         end
      end
      if (m_cmd == 2) begin
         for (int c = 0; c < 4; c++) m_out[c] = m_in[c];
         m_pd = 4'b0000;
      end
   endtask

   // Sends the low n bits MSB first; reports the clk index after cs rise of each pulse.
   task automatic send(input logic [63:0] bits, input int n, input int rst_at,
                       output int fv_k, output int err_k);
      dac_cs = 1'b0;
      clks(4);
      for (int i = n - 1; i >= 0; i--) begin
         spi_mosi = bits[i];
         spi_sck  = 1'b0;
         clks(4);
         spi_sck = 1'b1;
         clks(2);
`ifdef DAC_SPI_RX_READBACK_EN
         miso_word = {miso_word[30:0], spi_miso};
`endif
         clks(2);
         if (n - i == rst_at) begin
            rst = 1'b1;
            clks(2);
            rst = 1'b0;
         end
      end
      spi_sck = 1'b0;
      clks(4);
      dac_cs = 1'b1;
      fv_k  = 0;
      err_k = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (frame_valid) fv_k = (fv_k == 0) ? k : 99;
         if (frame_err) err_k = (err_k == 0) ? k : 99;
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".dac_out"}, 64'(dac_out), 64'({m_out[3], m_out[2], m_out[1], m_out[0]}));
      check({tag, ".pwr_dn"}, 64'(pwr_dn), 64'(m_pd));
      check({tag, ".rx"}, 64'({rx_cmd, rx_addr, rx_data}), 64'({m_cmd, m_addr, m_data}));
   endtask

   task automatic good_frame(input string tag, input logic [31:0] f, input bit clr_low);
      int fv_k, err_k;
      send(64'(f), 32, 0, fv_k, err_k);
      model_frame(f, clr_low);
      check({tag, ".fv_latency"}, 64'(fv_k), 64'd4);
      check({tag, ".no_err"}, 64'(err_k), 64'd0);
      check_state(tag);
   endtask

   task automatic bad_frame(input string tag, input logic [63:0] bits, input int n);
      int fv_k, err_k;
      send(bits, n, 0, fv_k, err_k);
      check({tag, ".no_fv"}, 64'(fv_k), 64'd0);
      check({tag, ".err_latency"}, 64'(err_k), 64'd4);
      check_state(tag);
   endtask

   initial begin
      int fv_k, err_k, n;
      logic [3:0]  cmd, addr;
      logic [31:0] f;
      logic [63:0] wide;

      rst = 1'b1;
      spi_sck = 1'b0;
      spi_mosi = 1'b0;
      dac_cs = 1'b1;
      dac_clr = 1'b1;
      model_reset();
      clks(3);
      check("reset.flags", 64'({frame_valid, frame_err}), 64'd0);
      check_state("reset");
      rst = 1'b0;
      clks(6);
      check("post_reset.flags", 64'({frame_valid, frame_err}), 64'd0);
      check_state("post_reset");

      good_frame("wr_upd_d", 32'h0033ABC0, 1'b0);
      good_frame("wr_all", 32'h000F1230, 1'b0);
      good_frame("upd_b", 32'h00110000, 1'b0);
      good_frame("pd_c", 32'h00420000, 1'b0);
      good_frame("wr_upd_c", 32'h00327FF0, 1'b0);
      good_frame("wr_upd_all", 32'h00209A50, 1'b0);
      good_frame("noop_bad_addr", 32'h00376540, 1'b0);
      bad_frame("short31", 64'h00000000_7FFFFFFF, 31);
      bad_frame("long33", 64'h00000001_0033FFF0, 33);

      dac_clr = 1'b0;
      clks(6);
      model_reset();
      m_cmd = rx_cmd; m_addr = rx_addr; m_data = rx_data;
      good_frame("clr_frame", 32'h003F5550, 1'b1);
      dac_clr = 1'b1;
      clks(6);

      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 7))
            0: cmd = 4'h0;
            1: cmd = 4'h1;
            2: cmd = 4'h2;
            3: cmd = 4'h3;
            4: cmd = 4'h4;
            5: cmd = 4'hF;
            default: cmd = 4'($urandom_range(5, 14));
         endcase
         case ($urandom_range(0, 5))
            4: addr = 4'hF;
            5: addr = 4'($urandom_range(4, 14));
            default: addr = 4'($urandom_range(0, 3));
         endcase
         f = {8'($urandom), cmd, addr, 12'($urandom), 4'($urandom)};
         if ($urandom_range(0, 5) == 0) begin
            n = ($urandom_range(0, 1) == 0) ? $urandom_range(28, 31) : $urandom_range(33, 36);
            wide = {32'($urandom), 32'($urandom)};
            bad_frame("rand_bad", wide, n);
         end else begin
            good_frame("rand_good", f, 1'b0);
         end
      end

      send(64'h00345670, 32, 16, fv_k, err_k);
      model_reset();
      check("rst_mid.no_fv", 64'(fv_k), 64'd0);
      check("rst_mid.no_err", 64'(err_k), 64'd0);
      check_state("rst_mid");
      clks(6);
      good_frame("after_rst", 32'h0030FFF0, 1'b0);

`ifdef DAC_SPI_RX_READBACK_EN
      good_frame("rb_first", 32'h0033ABC0, 1'b0);
      miso_word = '0;
      good_frame("rb_second", 32'h00F00000, 1'b0);
      check("rb.miso_stream", 64'(miso_word), 64'h0033ABC0);
      check("rb.miso_idle", 64'(spi_miso), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
